// File: rtl/asm_char_streamer.sv
// asm_char_streamer: streams text BRAM bytes as a whitespace-normalised ASCII strobe stream with line tracking.
// Ports: clk_in/rst_n_in (async active-low), start_in pulse, hold_in stall in GAP,
//        mem_addr_out/mem_data_in (2-cycle read latency), valid_data_out, new_character_out,
//        ascii_out, line_num_out, busy_out, done_out.
// Optional: define ASM_STREAMER_COMMENT_STRIP_EN to drop '#' comments up to the next newline.
module asm_char_streamer #(
    parameter int ADDR_WIDTH = 12,
    parameter int GAP_CYCLES = 1
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  start_in,
    input  logic                  hold_in,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    input  logic [7:0]            mem_data_in,
    output logic                  valid_data_out,
    output logic                  new_character_out,
    output logic [7:0]            ascii_out,
    output logic [15:0]           line_num_out,
    output logic                  busy_out,
    output logic                  done_out
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, SAMPLE, EMIT, GAP, DONE} state_t;
    state_t      state;
    logic        prev_space;
    logic        comment_drop;
    logic        drop;
    logic        last_addr;
    logic [3:0]  gap_cnt;
    logic [7:0]  ch;
    always_comb begin
        ch        = (mem_data_in == 8'h09) ? 8'h20 : mem_data_in;
        last_addr = &mem_addr_out;
        drop      = comment_drop || mem_data_in == 8'h0D || (ch == 8'h20 && prev_space);
    end
`ifdef ASM_STREAMER_COMMENT_STRIP_EN
    logic in_comment;
    // '#' opens a comment; only the closing newline leaves it (and is emitted)
    assign comment_drop = in_comment ? (mem_data_in != 8'h0A) : (mem_data_in == 8'h23);
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            in_comment <= 1'b0;
        else if (state == IDLE)
            in_comment <= 1'b0;
        else if (state == SAMPLE && mem_data_in != 8'h00)
            in_comment <= comment_drop;
    end
`else
    assign comment_drop = 1'b0;
`endif
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state             <= IDLE;
            mem_addr_out      <= '0;
            valid_data_out    <= 1'b0;
            new_character_out <= 1'b0;
            ascii_out         <= 8'h00;
            line_num_out      <= 16'h0000;
            busy_out          <= 1'b0;
            done_out          <= 1'b0;
            prev_space        <= 1'b0;
            gap_cnt           <= 4'h0;
        end else begin
            case (state)
                IDLE: if (start_in) begin
                    mem_addr_out   <= '0;
                    line_num_out   <= 16'h0001;
                    valid_data_out <= 1'b1;
                    busy_out       <= 1'b1;
                    prev_space     <= 1'b1;
                    state          <= FETCH;
                end
                FETCH: state <= WAIT;
                WAIT:  state <= SAMPLE;
                SAMPLE: begin
                    // the last address ends the stream; a dropped byte there ends it at once
                    if (mem_data_in == 8'h00 || (drop && last_addr)) begin
                        valid_data_out <= 1'b0;
                        done_out       <= 1'b1;
                        state          <= DONE;
                    end else if (drop) begin
                        mem_addr_out <= mem_addr_out + ADDR_WIDTH'(1);
                        state        <= FETCH;
                    end else begin
                        ascii_out         <= ch;
                        new_character_out <= 1'b1;
                        prev_space        <= ch == 8'h0A || ch == 8'h20;
                        state             <= EMIT;
                    end
                end
                EMIT: begin
                    new_character_out <= 1'b0;
                    gap_cnt           <= 4'(GAP_CYCLES - 1);
                    state             <= GAP;
                    if (ascii_out == 8'h0A && line_num_out != 16'hFFFF)
                        line_num_out <= line_num_out + 16'd1;
                end
                GAP: begin
                    if (gap_cnt != 4'h0)
                        gap_cnt <= gap_cnt - 4'h1;
                    else if (!hold_in && last_addr) begin
                        valid_data_out <= 1'b0;
                        done_out       <= 1'b1;
                        state          <= DONE;
                    end else if (!hold_in) begin
                        mem_addr_out <= mem_addr_out + ADDR_WIDTH'(1);
                        state        <= FETCH;
                    end
                end
                DONE: begin
                    done_out <= 1'b0;
                    busy_out <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_asm_char_streamer.sv
// tb_asm_char_streamer: randomized and directed checks of asm_char_streamer against a behavioural text model.
module tb_asm_char_streamer;
    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;
    localparam int GAP   = 1;
`ifdef ASM_STREAMER_COMMENT_STRIP_EN
    localparam bit STRIP = 1'b1;
`else
    localparam bit STRIP = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          rst_n_in = 1'b0;
    logic          start_in = 1'b0;
    logic          hold_in = 1'b0;
    logic [AW-1:0] mem_addr_out;
    logic [7:0]    mem_data_in;
    logic          valid_data_out;
    logic          new_character_out;
    logic [7:0]    ascii_out;
    logic [15:0]   line_num_out;
    logic          busy_out;
    logic          done_out;

    asm_char_streamer #(.ADDR_WIDTH(AW), .GAP_CYCLES(GAP)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in), .hold_in(hold_in),
        .mem_addr_out(mem_addr_out), .mem_data_in(mem_data_in),
        .valid_data_out(valid_data_out), .new_character_out(new_character_out),
        .ascii_out(ascii_out), .line_num_out(line_num_out),
        .busy_out(busy_out), .done_out(done_out)
    );

    always #5 clk_in = ~clk_in;

    logic [7:0] mem [DEPTH];
    logic [7:0] rd_pipe;
    always @(posedge clk_in) begin
        rd_pipe     <= mem[mem_addr_out];
        mem_data_in <= rd_pipe;
    end

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    logic [7:0]  got_ch [$];
    logic [15:0] got_ln [$];
    int          got_cy [$];
    int          done_cnt, done_cy, max_addr, bad_valid;
    logic [15:0] done_line;
    always @(negedge clk_in) begin
        if (new_character_out) begin
            got_ch.push_back(ascii_out);
            got_ln.push_back(line_num_out);
            got_cy.push_back(cyc);
            if (!valid_data_out || done_out) bad_valid++;
        end
        if (done_out) begin
            done_cnt++;
            done_cy   = cyc;
            done_line = line_num_out;
        end
        if (busy_out && int'(mem_addr_out) > max_addr) max_addr = int'(mem_addr_out);
    end

    logic [7:0]  exp_ch [$];
    logic [15:0] exp_ln [$];
    int          exp_cy [$];
    int          exp_done, exp_last;
    logic [15:0] exp_line;
    int          n_cmp = 0, n_bad = 0, t0 = 0;

    task automatic tick();
        @(negedge clk_in);
        #1;
    endtask

    task automatic load_str(input string s);
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
        for (int i = 0; i < s.len() && i < DEPTH; i++) mem[i] = s[i];
    endtask

    // Walk the text as the spec describes it: per-byte rules, cost 3 per drop and 4+GAP per emit.
    task automatic build_model();
        int f = 1;
        int line = 1;
        bit ps = 1'b1;
        bit cm = 1'b0;
        exp_ch.delete(); exp_ln.delete(); exp_cy.delete();
        exp_done = -1;
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] b, c;
            bit em;
            b = mem[i];
            exp_last = i;
            if (b == 8'h00) begin
                exp_done = f + 3;
                break;
            end
            c  = (b == 8'h09) ? 8'h20 : b;
            em = !(cm && b != 8'h0A) && b != 8'h0D && !(STRIP && !cm && b == 8'h23) && !(c == 8'h20 && ps);
            if (STRIP && !cm && b == 8'h23) cm = 1'b1;
            if (em) begin
                exp_ch.push_back(c);
                exp_ln.push_back(16'(line));
                exp_cy.push_back(f + 3);
                if (c == 8'h0A) begin
                    if (line < 65535) line++;
                    cm = 1'b0;
                end
                ps = (c == 8'h0A || c == 8'h20);
                f += 4 + GAP;
            end else begin
                f += 3;
            end
            if (i == DEPTH - 1) exp_done = f;
        end
        exp_line = 16'(line);
    endtask

    task automatic start_stream();
        got_ch.delete(); got_ln.delete(); got_cy.delete();
        done_cnt = 0; max_addr = -1; bad_valid = 0;
        tick();
        start_in = 1'b1;
        t0 = cyc;
        tick();
        start_in = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 4000 && done_cnt == 0; k++) tick();
        n_cmp++;
        if (done_cnt == 0) begin
            n_bad++;
            $display("FAIL %s timeout: done_out not seen, required within 4000 cycles", name);
        end
        repeat (3) tick();
    endtask

    task automatic check_run(input string name, input int extra);
        n_cmp++;
        if (got_ch.size() != exp_ch.size()) begin
            n_bad++;
            $display("FAIL %s strobe_count: got %0d required %0d", name, got_ch.size(), exp_ch.size());
        end
        for (int i = 0; i < got_ch.size() && i < exp_ch.size(); i++) begin
            int ex;
            ex = exp_cy[i] + (i > 0 ? extra : 0);
            n_cmp++;
            if (got_ch[i] !== exp_ch[i]) begin
                n_bad++;
                $display("FAIL %s char[%0d]: got %h required %h", name, i, got_ch[i], exp_ch[i]);
            end
            n_cmp++;
            if (got_ln[i] !== exp_ln[i]) begin
                n_bad++;
                $display("FAIL %s line[%0d]: got %0d required %0d", name, i, got_ln[i], exp_ln[i]);
            end
            n_cmp++;
            if (got_cy[i] - t0 != ex) begin
                n_bad++;
                $display("FAIL %s strobe_cycle[%0d]: got %0d required %0d", name, i, got_cy[i] - t0, ex);
            end
        end
        n_cmp++;
        if (done_cnt != 1) begin
            n_bad++;
            $display("FAIL %s done_pulses: got %0d required 1", name, done_cnt);
        end
        n_cmp++;
        if (done_cy - t0 != exp_done + (exp_ch.size() > 1 ? extra : 0)) begin
            n_bad++;
            $display("FAIL %s done_cycle: got %0d required %0d", name, done_cy - t0, exp_done);
        end
        n_cmp++;
        if (done_line !== exp_line) begin
            n_bad++;
            $display("FAIL %s final_line: got %0d required %0d", name, done_line, exp_line);
        end
        n_cmp++;
        if (max_addr != exp_last) begin
            n_bad++;
            $display("FAIL %s last_addr: got %0d required %0d", name, max_addr, exp_last);
        end
        n_cmp++;
        if (bad_valid != 0) begin
            n_bad++;
            $display("FAIL %s valid_on_strobe: got %0d bad strobes required 0", name, bad_valid);
        end
    endtask

    task automatic check_text(input string name, input string want);
        string g = "";
        foreach (got_ch[i]) g = $sformatf("%s%c", g, got_ch[i]);
        n_cmp++;
        if (g != want) begin
            n_bad++;
            $display("FAIL %s text: got \"%s\" required \"%s\"", name, g, want);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
        tick(); tick();
        n_cmp++;
        if ({mem_addr_out, valid_data_out, new_character_out, ascii_out, line_num_out, busy_out, done_out} !== '0) begin
            n_bad++;
            $display("FAIL reset_values: got addr=%h v=%b s=%b a=%h l=%h b=%b d=%b required all 0",
                     mem_addr_out, valid_data_out, new_character_out, ascii_out, line_num_out, busy_out, done_out);
        end
        rst_n_in = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        load_str("addi x1, x0, 0x1F\n");
        build_model();
        start_stream();
        wait_done("basic");
        check_run("basic", 0);
        check_text("basic", "addi x1, x0, 0x1F\n");
    endtask

    task automatic test_whitespace();
        load_str("  \t li\t\t x5 ,\015\n");
        build_model();
        start_stream();
        wait_done("whitespace");
        check_run("whitespace", 0);
        check_text("whitespace", "li x5 ,\n");
    endtask

    task automatic test_comments();
        load_str("nop # jump 0x40\nret");
        build_model();
        start_stream();
        wait_done("comments");
        check_run("comments", 0);
        check_text("comments", STRIP ? "nop \nret" : "nop # jump 0x40\nret");
        n_cmp++;
        if (got_ln.size() < 3 || got_ln[got_ln.size() - 3] !== 16'd2) begin
            n_bad++;
            $display("FAIL comments r_line: got %0d required 2", got_ln.size() < 3 ? 0 : got_ln[got_ln.size() - 3]);
        end
    endtask

    task automatic test_hold();
        load_str("addi x1, x0, 0x1F\n");
        build_model();
        hold_in = 1'b1;
        start_stream();
        hold_in = 1'b0;
        n_cmp++;
        if (busy_out !== 1'b1) begin
            n_bad++;
            $display("FAIL hold start_with_hold: busy got %b required 1", busy_out);
        end
        for (int k = 0; k < 100 && got_ch.size() == 0; k++) tick();
        tick();
        hold_in = 1'b1;
        repeat (10) tick();
        hold_in = 1'b0;
        wait_done("hold");
        check_run("hold", 10);
    endtask

    task automatic test_end_of_memory();
        string cs = "abcxyz019,";
        for (int i = 0; i < DEPTH; i++) mem[i] = cs[$urandom_range(0, cs.len() - 1)];
        build_model();
        start_stream();
        wait_done("end_of_mem");
        check_run("end_of_mem", 0);
    endtask

    task automatic test_random();
        string cs = "ab #\t\n\015x1,";
        for (int r = 0; r < 8; r++) begin
            int len;
            len = $urandom_range(0, DEPTH);
            for (int i = 0; i < DEPTH; i++)
                mem[i] = (i < len) ? cs[$urandom_range(0, cs.len() - 1)] : 8'h00;
            build_model();
            start_stream();
            wait_done($sformatf("random%0d", r));
            check_run($sformatf("random%0d", r), 0);
        end
    endtask

    task automatic test_midstream_reset();
        load_str("addi x1, x0, 0x1F\n");
        start_stream();
        for (int k = 0; k < 100 && got_ch.size() == 0; k++) tick();
        tick();
        rst_n_in = 1'b0;
        #1;
        n_cmp++;
        if ({mem_addr_out, valid_data_out, new_character_out, ascii_out, line_num_out, busy_out, done_out} !== '0) begin
            n_bad++;
            $display("FAIL midreset outputs: got addr=%h v=%b s=%b a=%h l=%h b=%b d=%b required all 0",
                     mem_addr_out, valid_data_out, new_character_out, ascii_out, line_num_out, busy_out, done_out);
        end
        repeat (3) tick();
        rst_n_in = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (done_cnt != 0) begin
            n_bad++;
            $display("FAIL midreset no_done: got %0d done pulses required 0", done_cnt);
        end
        load_str("  \t li\t\t x5 ,\015\n");
        build_model();
        start_stream();
        wait_done("restart");
        check_run("restart", 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_whitespace();
        test_comments();
        test_hold();
        test_end_of_memory();
        test_random();
        test_midstream_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
